// File: rtl/rx_pack_defs.sv
// ============================================================================
// Module      : rx_pack_defs (package)
// Description : Shared definitions for the RX character packer: FSM state
//               encoding and the width of the valid-lane count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_pack_defs;

    // Width of Byte_Count / lane index; holds 0..8 lanes.
    localparam int BYTE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_RECV    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_pack_control_module_if.sv
// ============================================================================
// Module      : rx_pack_control_module_if
// Description : Receiver / FIFO side bus of the RX character packer.
//   master : the packer (drives RX_En_Sig, Write_Req_Sig, FIFO_Write_Data,
//            Byte_Count, Drop_Count; samples RX_Done_Sig, RX_Data,
//            Flush_Sig, Full_Sig)
//   slave  : the surrounding receiver / FIFO logic (opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_pack_control_module_if #(
    parameter int DATA_W = 8,
    parameter int PACK_N = 4
);

    logic                                 RX_Done_Sig;
    logic [DATA_W-1:0]                    RX_Data;
    logic                                 RX_En_Sig;
    logic                                 Flush_Sig;
    logic                                 Full_Sig;
    logic                                 Write_Req_Sig;
    logic [DATA_W*PACK_N-1:0]             FIFO_Write_Data;
    logic [rx_pack_defs::BYTE_CNT_W-1:0]  Byte_Count;
    logic [15:0]                          Drop_Count;

    modport master (
        input  RX_Done_Sig, RX_Data, Flush_Sig, Full_Sig,
        output RX_En_Sig, Write_Req_Sig, FIFO_Write_Data, Byte_Count, Drop_Count
    );

    modport slave (
        output RX_Done_Sig, RX_Data, Flush_Sig, Full_Sig,
        input  RX_En_Sig, Write_Req_Sig, FIFO_Write_Data, Byte_Count, Drop_Count
    );

endinterface

`default_nettype wire

// File: rtl/rx_idle_timer.sv
// ============================================================================
// Module      : rx_idle_timer
// Description : Idle-cycle counter. Counts while run=1, restarts on clear,
//               and raises expire once TIMEOUT_CYC-1 is reached.
//               TIMEOUT_CYC=0 removes the counter and holds expire at 0.
//   CLK    in  clock (posedge)
//   RSTn   in  asynchronous active-low reset
//   clear  in  restart the count (priority over run)
//   run    in  count enable
//   expire out run && count == TIMEOUT_CYC-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_idle_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic CLK,
    input  wire logic RSTn,
    input  wire logic clear,
    input  wire logic run,
    output logic      expire
);

    if (TIMEOUT_CYC == 0) begin : g_disabled
        logic w_unused;
        assign w_unused = &{1'b0, CLK, RSTn, clear, run};
        assign expire   = 1'b0;
    end else begin : g_enabled
        localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
        localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYC - 1);

        logic [CNT_W-1:0] r_cnt;

        // Holds at c_LAST so a long stall never wraps back to zero.
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                r_cnt <= '0;
            end else if (clear) begin
                r_cnt <= '0;
            end else if (run && (r_cnt != c_LAST)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign expire = run && (r_cnt == c_LAST);
    end

endmodule

`default_nettype wire

// File: rtl/rx_pack_control_module.sv
// ============================================================================
// Module      : rx_pack_control_module
// Description : Packs PACK_N received characters into one FIFO word
//               (character 0 in the LSB lane). Partial words are written on
//               Flush_Sig or after TIMEOUT_CYC idle cycles. On FIFO full the
//               block stalls (FULL_MODE=0) or drops the word (FULL_MODE=1).
//   CLK   in   clock (posedge)
//   RSTn  in   asynchronous active-low reset
//   bus   master modport: RX_Done_Sig/RX_Data/Flush_Sig/Full_Sig in;
//         RX_En_Sig/Write_Req_Sig/FIFO_Write_Data/Byte_Count/Drop_Count out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_pack_control_module #(
    parameter int DATA_W      = 8,
    parameter int PACK_N      = 4,
    parameter int FULL_MODE   = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic                CLK,
    input  wire logic                RSTn,
    rx_pack_control_module_if.master bus
);

    import rx_pack_defs::*;

    localparam logic [BYTE_CNT_W-1:0] c_PACK_N = BYTE_CNT_W'(PACK_N);

    rx_state_t                r_state;
    logic [BYTE_CNT_W-1:0]    r_idx;
    logic [DATA_W*PACK_N-1:0] r_buf;
    logic                     r_rx_en;
    logic                     r_wr;
    logic [15:0]              r_drop;

    logic                     w_accept;
    logic [BYTE_CNT_W-1:0]    w_idx_next;
    logic                     w_run;
    logic                     w_clear;
    logic                     w_expire;

    // A character is only taken in RECV while a free lane exists; once the
    // word is full the FSM leaves RECV on the next edge.
    assign w_accept   = (r_state == ST_RECV) && bus.RX_Done_Sig && (r_idx < c_PACK_N);
    assign w_idx_next = r_idx + BYTE_CNT_W'(w_accept);
    assign w_run      = (r_state == ST_RECV) && (r_idx != '0);
    // Clearing whenever the timer is not running keeps each word's idle
    // count starting from zero.
    assign w_clear    = w_accept || !w_run;

    rx_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .clear  (w_clear),
        .run    (w_run),
        .expire (w_expire)
    );

    // RX_En_Sig and Write_Req_Sig are loaded with the value matching the
    // state being entered, so they track the state without decode glitches.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_RECV;
            r_idx   <= '0;
            r_buf   <= '0;
            r_rx_en <= 1'b0;
            r_wr    <= 1'b0;
            r_drop  <= '0;
        end else begin
            case (r_state)
                ST_RECV: begin
                    r_wr <= 1'b0;
                    if (w_accept) begin
                        for (int i = 0; i < PACK_N; i++) begin
                            if (r_idx == BYTE_CNT_W'(i)) begin
                                r_buf[i*DATA_W +: DATA_W] <= bus.RX_Data;
                            end
                        end
                        r_idx <= w_idx_next;
                    end
                    // Flush sees the lane count including a same-cycle store.
                    if ((r_idx == c_PACK_N) ||
                        (bus.Flush_Sig && (w_idx_next != '0)) ||
                        (w_expire && !w_accept)) begin
                        r_state <= ST_CHECK;
                        r_rx_en <= 1'b0;
                    end else begin
                        r_rx_en <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!bus.Full_Sig) begin
                        r_state <= ST_WRITE;
                        r_wr    <= 1'b1;
                    end else if (FULL_MODE != 0) begin
                        if (r_drop != 16'hFFFF) begin
                            r_drop <= r_drop + 16'd1;
                        end
                        r_buf   <= '0;
                        r_idx   <= '0;
                        r_state <= ST_RECV;
                        r_rx_en <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_RELEASE;
                    r_wr    <= 1'b0;
                end
                ST_RELEASE: begin
                    r_buf   <= '0;
                    r_idx   <= '0;
                    r_state <= ST_RECV;
                    r_rx_en <= 1'b1;
                    r_wr    <= 1'b0;
                end
                default: begin
                    r_state <= ST_RECV;
                end
            endcase
        end
    end

    assign bus.RX_En_Sig       = r_rx_en;
    assign bus.Write_Req_Sig   = r_wr;
    assign bus.FIFO_Write_Data = r_buf;
    assign bus.Byte_Count      = r_idx;
    assign bus.Drop_Count      = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_rx_pack_control_module.sv
// ============================================================================
// Module      : tb_rx_pack_control_module
// Description : Directed self-checking bench. dut0: PACK_N=4, stall on full,
//               16-cycle timeout. dut1: PACK_N=4, drop on full, no timeout.
//               dut2: PACK_N=1, stall on full, no timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_pack_control_module;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    rx_pack_control_module_if #(.DATA_W(8), .PACK_N(4)) bus0 ();
    rx_pack_control_module_if #(.DATA_W(8), .PACK_N(4)) bus1 ();
    rx_pack_control_module_if #(.DATA_W(8), .PACK_N(1)) bus2 ();

    rx_pack_control_module #(.DATA_W(8), .PACK_N(4), .FULL_MODE(0), .TIMEOUT_CYC(16))
        dut0 (.CLK(CLK), .RSTn(RSTn), .bus(bus0));
    rx_pack_control_module #(.DATA_W(8), .PACK_N(4), .FULL_MODE(1), .TIMEOUT_CYC(0))
        dut1 (.CLK(CLK), .RSTn(RSTn), .bus(bus1));
    rx_pack_control_module #(.DATA_W(8), .PACK_N(1), .FULL_MODE(0), .TIMEOUT_CYC(0))
        dut2 (.CLK(CLK), .RSTn(RSTn), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int wr1_cnt = 0;

    always @(posedge CLK) if (bus1.Write_Req_Sig === 1'b1) wr1_cnt++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send0(input logic [7:0] b);
        bus0.RX_Done_Sig = 1'b1;
        bus0.RX_Data     = b;
        tick();
        bus0.RX_Done_Sig = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        bus1.RX_Done_Sig = 1'b1;
        bus1.RX_Data     = b;
        tick();
        bus1.RX_Done_Sig = 1'b0;
    endtask

    // Observes dut0 for n edges; k=1 is the first edge after the call.
    task automatic watch0(input int n, output int pulses, output int first,
                          output logic [31:0] data, output logic [3:0] cnt,
                          output logic en_seen);
        pulses = 0; first = -1; data = '0; cnt = '0; en_seen = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus0.Write_Req_Sig === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    data  = bus0.FIFO_Write_Data;
                    cnt   = bus0.Byte_Count;
                end
            end
            if (bus0.RX_En_Sig !== 1'b0) en_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (bus0.RX_En_Sig !== 1'b0) begin errors++; $display("FAIL reset_rx_en got %b expected 0", bus0.RX_En_Sig); end
        checks++; if (bus0.Write_Req_Sig !== 1'b0) begin errors++; $display("FAIL reset_wr got %b expected 0", bus0.Write_Req_Sig); end
        checks++; if (bus0.Byte_Count !== 4'd0) begin errors++; $display("FAIL reset_byte_count got %0d expected 0", bus0.Byte_Count); end
        checks++; if (bus0.Drop_Count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d expected 0", bus0.Drop_Count); end
        checks++; if (bus0.FIFO_Write_Data !== 32'd0) begin errors++; $display("FAIL reset_data got %h expected 0", bus0.FIFO_Write_Data); end
        RSTn = 1'b1;
        tick();
        checks++; if (bus0.RX_En_Sig !== 1'b1) begin errors++; $display("FAIL release_rx_en got %b expected 1", bus0.RX_En_Sig); end
        checks++; if (bus2.RX_En_Sig !== 1'b1) begin errors++; $display("FAIL release_rx_en2 got %b expected 1", bus2.RX_En_Sig); end
    endtask

    task automatic test_full_word();
        int p, f; logic [31:0] d; logic [3:0] c; logic e;
        send0(8'h11); send0(8'h22); send0(8'h33); send0(8'h44);
        watch0(8, p, f, d, c, e);
        checks++; if (p !== 1) begin errors++; $display("FAIL full_pulses got %0d expected 1", p); end
        checks++; if (f !== 2) begin errors++; $display("FAIL full_latency got %0d expected 2", f); end
        checks++; if (d !== 32'h44332211) begin errors++; $display("FAIL full_data got %h expected 44332211", d); end
        checks++; if (c !== 4'd4) begin errors++; $display("FAIL full_count got %0d expected 4", c); end
        checks++; if (bus0.Byte_Count !== 4'd0) begin errors++; $display("FAIL full_release_count got %0d expected 0", bus0.Byte_Count); end
        checks++; if (bus0.RX_En_Sig !== 1'b1) begin errors++; $display("FAIL full_release_en got %b expected 1", bus0.RX_En_Sig); end
    endtask

    task automatic test_flush();
        int p, f; logic [31:0] d; logic [3:0] c; logic e;
        send0(8'hA1); send0(8'hB2);
        bus0.Flush_Sig = 1'b1; tick(); bus0.Flush_Sig = 1'b0;
        watch0(6, p, f, d, c, e);
        checks++; if (p !== 1) begin errors++; $display("FAIL flush_pulses got %0d expected 1", p); end
        checks++; if (f !== 1) begin errors++; $display("FAIL flush_latency got %0d expected 1", f); end
        checks++; if (d !== 32'h0000B2A1) begin errors++; $display("FAIL flush_data got %h expected 0000b2a1", d); end
        checks++; if (c !== 4'd2) begin errors++; $display("FAIL flush_count got %0d expected 2", c); end
        // Flush with an empty buffer must not produce a write.
        bus0.Flush_Sig = 1'b1; tick(); bus0.Flush_Sig = 1'b0;
        watch0(6, p, f, d, c, e);
        checks++; if (p !== 0) begin errors++; $display("FAIL flush_empty_pulses got %0d expected 0", p); end
    endtask

    task automatic test_timeout();
        int p, f; logic [31:0] d; logic [3:0] c; logic e;
        send0(8'h5A);
        watch0(25, p, f, d, c, e);
        checks++; if (p !== 1) begin errors++; $display("FAIL timeout_pulses got %0d expected 1", p); end
        checks++; if (f < 15 || f > 17) begin errors++; $display("FAIL timeout_latency got %0d expected 15..17", f); end
        checks++; if (c !== 4'd1) begin errors++; $display("FAIL timeout_count got %0d expected 1", c); end
        checks++; if (d !== 32'h0000005A) begin errors++; $display("FAIL timeout_data got %h expected 0000005a", d); end
    endtask

    task automatic test_full_stall();
        int p, f; logic [31:0] d; logic [3:0] c; logic e;
        int p_tot; logic e_tot;
        bus0.Full_Sig = 1'b1;
        send0(8'h01); send0(8'h02); send0(8'h03); send0(8'h04);
        watch0(1, p, f, d, c, e);
        p_tot = p; e_tot = e;
        send0(8'h99);  // must be ignored while stalled
        watch0(48, p, f, d, c, e);
        p_tot += p; e_tot |= e;
        checks++; if (p_tot !== 0) begin errors++; $display("FAIL stall_pulses got %0d expected 0", p_tot); end
        checks++; if (e_tot !== 1'b0) begin errors++; $display("FAIL stall_rx_en got %b expected 0", e_tot); end
        checks++; if (bus0.Byte_Count !== 4'd4) begin errors++; $display("FAIL stall_count got %0d expected 4", bus0.Byte_Count); end
        bus0.Full_Sig = 1'b0;
        watch0(4, p, f, d, c, e);
        checks++; if (f !== 1) begin errors++; $display("FAIL stall_release_latency got %0d expected 1", f); end
        checks++; if (d !== 32'h04030201) begin errors++; $display("FAIL stall_data got %h expected 04030201", d); end
        checks++; if (p !== 1) begin errors++; $display("FAIL stall_release_pulses got %0d expected 1", p); end
    endtask

    task automatic test_drop();
        bus1.Full_Sig = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) send1(8'(16 * w + b + 1));
            tick(); tick(); tick();
            if (w == 0) begin
                checks++; if (bus1.Drop_Count !== 16'd1) begin errors++; $display("FAIL drop_first got %0d expected 1", bus1.Drop_Count); end
            end
        end
        checks++; if (bus1.Drop_Count !== 16'd3) begin errors++; $display("FAIL drop_count got %0d expected 3", bus1.Drop_Count); end
        checks++; if (wr1_cnt !== 0) begin errors++; $display("FAIL drop_write_pulses got %0d expected 0", wr1_cnt); end
        checks++; if (bus1.Byte_Count !== 4'd0) begin errors++; $display("FAIL drop_byte_count got %0d expected 0", bus1.Byte_Count); end
        checks++; if (bus1.RX_En_Sig !== 1'b1) begin errors++; $display("FAIL drop_rx_en got %b expected 1", bus1.RX_En_Sig); end
        bus1.Full_Sig = 1'b0;
    endtask

    task automatic test_pack1();
        logic [7:0] vals [2];
        vals[0] = 8'h7E; vals[1] = 8'h81;
        for (int n = 0; n < 2; n++) begin
            int first; logic [7:0] d; logic [3:0] c;
            first = -1; d = '0; c = '0;
            bus2.RX_Done_Sig = 1'b1; bus2.RX_Data = vals[n]; tick(); bus2.RX_Done_Sig = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                tick();
                if (bus2.Write_Req_Sig === 1'b1 && first < 0) begin
                    first = k; d = bus2.FIFO_Write_Data; c = bus2.Byte_Count;
                end
            end
            checks++; if (first !== 2) begin errors++; $display("FAIL pack1_latency got %0d expected 2", first); end
            checks++; if (d !== vals[n]) begin errors++; $display("FAIL pack1_data got %h expected %h", d, vals[n]); end
            checks++; if (c !== 4'd1) begin errors++; $display("FAIL pack1_count got %0d expected 1", c); end
        end
    endtask

    task automatic test_reset_in_check();
        int p, f; logic [31:0] d; logic [3:0] c; logic e;
        bus0.Full_Sig = 1'b1;
        send0(8'hC1); send0(8'hC2); send0(8'hC3); send0(8'hC4);
        tick(); tick();
        checks++; if (bus0.RX_En_Sig !== 1'b0) begin errors++; $display("FAIL rst_chk_precheck got %b expected 0", bus0.RX_En_Sig); end
        RSTn = 1'b0;
        #1;
        checks++; if (bus0.Write_Req_Sig !== 1'b0) begin errors++; $display("FAIL rst_chk_wr got %b expected 0", bus0.Write_Req_Sig); end
        checks++; if (bus0.Byte_Count !== 4'd0) begin errors++; $display("FAIL rst_chk_count got %0d expected 0", bus0.Byte_Count); end
        checks++; if (bus0.FIFO_Write_Data !== 32'd0) begin errors++; $display("FAIL rst_chk_data got %h expected 0", bus0.FIFO_Write_Data); end
        checks++; if (bus0.RX_En_Sig !== 1'b0) begin errors++; $display("FAIL rst_chk_en got %b expected 0", bus0.RX_En_Sig); end
        bus0.Full_Sig = 1'b0;
        tick(); tick();
        RSTn = 1'b1;
        watch0(5, p, f, d, c, e);
        checks++; if (p !== 0) begin errors++; $display("FAIL rst_chk_no_write got %0d expected 0", p); end
        checks++; if (bus0.RX_En_Sig !== 1'b1) begin errors++; $display("FAIL rst_chk_release_en got %b expected 1", bus0.RX_En_Sig); end
    endtask

    initial begin
        bus0.RX_Done_Sig = 1'b0; bus0.RX_Data = '0; bus0.Flush_Sig = 1'b0; bus0.Full_Sig = 1'b0;
        bus1.RX_Done_Sig = 1'b0; bus1.RX_Data = '0; bus1.Flush_Sig = 1'b0; bus1.Full_Sig = 1'b0;
        bus2.RX_Done_Sig = 1'b0; bus2.RX_Data = '0; bus2.Flush_Sig = 1'b0; bus2.Full_Sig = 1'b0;
        test_reset();
        test_full_word();
        test_flush();
        test_timeout();
        test_full_stall();
        test_drop();
        test_pack1();
        test_reset_in_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx_pack_control_module.md
RX_PACK_CONTROL_MODULE -- requirements
Module: rx_pack_control_module

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, meaning the width of one received character.
REQ-002 The block SHALL expose parameter PACK_N, default 4, meaning the number of characters per FIFO word (legal range 1..8).
REQ-003 The block SHALL expose parameter FULL_MODE, default 0, meaning 0 = stall on full and 1 = drop word on full.
REQ-004 The block SHALL expose parameter TIMEOUT_CYC, default 1024, meaning the number of idle cycles before a partial word is flushed (0 disables the timeout).
REQ-005 The block SHALL have port CLK  input  1  system clock, with all logic on posedge.
REQ-006 The block SHALL have port RSTn  input  1  reset, asynchronous and active-low.
REQ-007 The block SHALL have port RX_Done_Sig  input  1  one-cycle strobe, character valid on RX_Data.
REQ-008 The block SHALL have port RX_Data  input  DATA_W  received character.
REQ-009 The block SHALL have port RX_En_Sig  output  1  receiver enable.
REQ-010 The block SHALL have port Flush_Sig  input  1  request to write a partial word immediately.
REQ-011 The block SHALL have port Full_Sig  input  1  FIFO full.
REQ-012 The block SHALL have port Write_Req_Sig  output  1  FIFO write strobe, one cycle.
REQ-013 The block SHALL have port FIFO_Write_Data  output  DATA_W*PACK_N  packed word, character 0 in the LSB lane.
REQ-014 The block SHALL have port Byte_Count  output  4  number of valid lanes in FIFO_Write_Data.
REQ-015 The block SHALL have port Drop_Count  output  16  saturating count of dropped words.

Function
REQ-016 The FSM SHALL have states RECV, CHECK, WRITE and RELEASE, with RECV as the reset state.
REQ-017 In RECV, RX_En_Sig SHALL be 1; in every other state, RX_En_Sig SHALL be 0.
REQ-018 In RECV, RX_Done_Sig SHALL store RX_Data into lane idx and increment idx.
REQ-019 RECV SHALL move to CHECK when idx reaches PACK_N.
REQ-020 RECV SHALL move to CHECK when Flush_Sig=1 and idx>0 (after any same-cycle store).
REQ-021 RECV SHALL move to CHECK when the idle timeout expires and idx>0.
REQ-022 Flush_Sig SHALL be ignored when idx=0.
REQ-023 The idle counter SHALL clear on every accepted character and SHALL count only when in RECV with idx>0.
REQ-024 The timeout SHALL expire when the idle counter equals TIMEOUT_CYC-1.
REQ-025 In CHECK with Full_Sig=0, the FSM SHALL move to WRITE.
REQ-026 In CHECK with Full_Sig=1 and FULL_MODE=0, the FSM SHALL remain in CHECK; no characters are accepted while it does.
REQ-027 In CHECK with Full_Sig=1 and FULL_MODE=1, the block SHALL increment Drop_Count (saturating at 16'hFFFF), clear the buffer and idx, and return to RECV.
REQ-028 Write_Req_Sig SHALL be registered and SHALL be 1 for exactly the one cycle the FSM spends in WRITE.
REQ-029 WRITE SHALL always move to RELEASE.
REQ-030 RELEASE SHALL clear the buffer and idx, hold Write_Req_Sig at 0, and return to RECV.
REQ-031 Latency: Write_Req_Sig SHALL rise on the second edge after the edge that samples the final RX_Done_Sig, provided Full_Sig=0.
REQ-032 FIFO_Write_Data and Byte_Count SHALL be stable from CHECK entry through the WRITE cycle.
REQ-033 Unused lanes SHALL read as 0.
REQ-034 RX_Done_Sig outside RECV SHALL be ignored and counted as neither data nor drop.
REQ-035 With PACK_N=1, FULL_MODE=0 and TIMEOUT_CYC=0, the block SHALL reproduce the single-character control behaviour: one character per write, stalling on full.

Reset
REQ-036 Assertion of RSTn=0 SHALL asynchronously force: state=RECV, idx=0, buffer=0, idle counter=0, RX_En_Sig=0, Write_Req_Sig=0, Byte_Count=0 and Drop_Count=0.
REQ-037 The first cycle after reset release SHALL drive RX_En_Sig=1.
REQ-038 A reset during CHECK or WRITE SHALL abort the word with no write strobe.

Structure
REQ-039 State encodings and the Byte_Count width SHALL live in the shared header rx_pack_defs.
REQ-040 The idle timeout SHALL be implemented as the sub-module rx_idle_timer, with inputs clear and run and output expire.

Verification
REQ-041 Scenario: PACK_N=4; bytes 11,22,33,44 are received with Full_Sig=0 -> one Write_Req_Sig pulse, FIFO_Write_Data=32'h44332211, Byte_Count=4.
REQ-042 Scenario: bytes A1,B2 are received, then Flush_Sig is pulsed -> write with FIFO_Write_Data=32'h0000B2A1 and Byte_Count=2.
REQ-043 Scenario: TIMEOUT_CYC=16 and one byte 5A is received -> write on cycle 16 (±1) after the byte, with Byte_Count=1.
REQ-044 Scenario: FULL_MODE=0 with Full_Sig held 1 for 50 cycles -> RX_En_Sig=0 throughout, and the write occurs 1 cycle after Full_Sig falls.
REQ-045 Scenario: FULL_MODE=1 with Full_Sig=1 and 3 full words received -> Drop_Count=3 and no Write_Req_Sig.
REQ-046 Scenario: RSTn is pulsed low while in CHECK -> all outputs are 0 immediately, no write occurs, and RX_En_Sig=1 after release.
